reg_file_issue: RTL

- Operand-fetch/issue stage directly downstream of decode_reg_file.
- Consumes the decoded reg_file_read_params_t (rs1, rs2, rd) plus a writes-rd flag, and holds the 32 x XLEN architectural register file.
- Tracks pending writes in a busy-bit scoreboard, bypasses same-cycle writeback data, and presents operands to execute through a one-entry valid/ready output register.
- Stalls decode on RAW/WAW hazards.

---
 rtl/reg_file_pkg.sv | 24 ++
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/reg_file_issue.sv | 116 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types for the decode/operand-fetch boundary
package reg_file_pkg;

  localparam int REG_XLEN    = 32;
  localparam int REG_IDX_W   = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = '0;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
  } reg_file_read_params_t;

  typedef struct packed {
    logic [REG_XLEN-1:0] rs1_data;
    logic [REG_XLEN-1:0] rs2_data;
    reg_idx_t            rd;
    logic                writes_rd;
  } issue_packet_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - busy-bit scoreboard with RAW/WAW hazard detection
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  logic                flush_clr_en,
  input  reg_idx_t            flush_clr_idx,
  input  logic                bypass_valid,
  input  reg_idx_t            bypass_idx,
  input  reg_idx_t            rs1,
  input  reg_idx_t            rs2,
  input  reg_idx_t            rd,
  input  logic                writes_rd,
  output logic                hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;

  // Set is applied last so a new issue wins over a same-index clear.
  always_comb begin
    busy_next = busy;
    if (clr_en)       busy_next[clr_idx]       = 1'b0;
    if (flush_clr_en) busy_next[flush_clr_idx] = 1'b0;
    if (set_en)       busy_next[set_idx]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign rs1_busy = busy[rs1] & ~(bypass_valid & (bypass_idx == rs1));
  assign rs2_busy = busy[rs2] & ~(bypass_valid & (bypass_idx == rs2));
  assign rd_busy  = writes_rd & busy[rd] & (rd != REG_X0);
  assign hazard   = rs1_busy | rs2_busy | rd_busy;

endmodule

// File: rtl/reg_file_issue.sv
// rtl/reg_file_issue.sv - register file, operand bypass and one-entry issue register
module reg_file_issue
  import reg_file_pkg::*;
#(
  parameter int XLEN      = REG_XLEN,
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  reg_file_read_params_t in_params,
  input  logic                 in_writes_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_data,
  output logic [XLEN-1:0]      out_rs2_data,
  output reg_idx_t             out_rd,
  output logic                 out_writes_rd,
  input  logic                 wb_valid,
  input  reg_idx_t             wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush
);

  logic [XLEN-1:0] regs [NUM_REGS];
  issue_packet_t   out_pkt;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            wb_fwd;
  logic            hazard;
  logic            slot_free;
  logic            issue;
  logic            set_en;
  logic            flush_clr_en;

  assign wb_fwd    = BYPASS_EN & wb_valid;
  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = slot_free & ~hazard & ~flush & rst_n;
  assign issue     = in_valid & in_ready;
  assign set_en    = issue & in_writes_rd & (in_params.rd != REG_X0);
  // A flushed packet will never write back, so release its destination.
  assign flush_clr_en = flush & out_valid & out_pkt.writes_rd & (out_pkt.rd != REG_X0);

  always_comb begin
    rs1_val = regs[in_params.rs1];
    if (in_params.rs1 == REG_X0) begin
      rs1_val = '0;
    end else if (wb_fwd && (wb_rd == in_params.rs1)) begin
      rs1_val = wb_data;
    end
  end

  always_comb begin
    rs2_val = regs[in_params.rs2];
    if (in_params.rs2 == REG_X0) begin
      rs2_val = '0;
    end else if (wb_fwd && (wb_rd == in_params.rs2)) begin
      rs2_val = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid && (wb_rd != REG_X0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_pkt   <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_pkt.rs1_data  <= rs1_val;
      out_pkt.rs2_data  <= rs2_val;
      out_pkt.rd        <= in_params.rd;
      out_pkt.writes_rd <= in_writes_rd;
      out_valid         <= 1'b1;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs1_data  = out_pkt.rs1_data;
  assign out_rs2_data  = out_pkt.rs2_data;
  assign out_rd        = out_pkt.rd;
  assign out_writes_rd = out_pkt.writes_rd;

  reg_scoreboard #(
    .NUM_REGS(NUM_REGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_en        (set_en),
    .set_idx       (in_params.rd),
    .clr_en        (wb_valid),
    .clr_idx       (wb_rd),
    .flush_clr_en  (flush_clr_en),
    .flush_clr_idx (out_pkt.rd),
    .bypass_valid  (wb_fwd),
    .bypass_idx    (wb_rd),
    .rs1           (in_params.rs1),
    .rs2           (in_params.rs2),
    .rd            (in_params.rd),
    .writes_rd     (in_writes_rd),
    .hazard        (hazard)
  );

endmodule
